// File: rtl/rx_cmd_ctrl_if.sv
// UART command controller bus: received-byte stream in,
// register-file / ALU control strobes out.
interface rx_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] RX_P_Data;
  logic                  RX_D_VLD;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  ALU_EN;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  CLK_GATE_EN;
  logic                  CMD_Busy;
  logic                  CMD_ERR;

  modport master (
    output RX_P_Data, RX_D_VLD,
    input  WrEn, RdEn, Address, WrData,
    input  ALU_EN, ALU_FUN, CLK_GATE_EN,
    input  CMD_Busy, CMD_ERR
  );

  modport slave (
    input  RX_P_Data, RX_D_VLD,
    output WrEn, RdEn, Address, WrData,
    output ALU_EN, ALU_FUN, CLK_GATE_EN,
    output CMD_Busy, CMD_ERR
  );
endinterface

// File: rtl/rx_cmd_ctrl.sv
// Decodes UART command frames (write/read/ALU) into
// registered register-file and ALU strobes with inter-byte timeout.
module rx_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 1023
) (
  input logic         CLK,
  input logic         RST,
  rx_cmd_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_ADDR    = 3'd1;
  localparam logic [2:0] WR_DATA    = 3'd2;
  localparam logic [2:0] RD_ADDR    = 3'd3;
  localparam logic [2:0] OP_A       = 3'd4;
  localparam logic [2:0] OP_B       = 3'd5;
  localparam logic [2:0] ALU_FUN_ST = 3'd6;

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [DATA_WIDTH-1:0] OPC_WR  =
    DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OPC_RD  =
    DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU =
    DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OPC_FUN =
    DATA_WIDTH'(8'hDD);

  logic [2:0]            state_q, state_d;
  logic [2:0]            src;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] acap_q, acap_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  alu_q, alu_d;
  logic                  gate_q, gate_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  vld, tmo;
  logic [DATA_WIDTH-1:0] din;

  assign vld = bus.RX_D_VLD;
  assign din = bus.RX_P_Data;

  // A byte landing on the timeout cycle is decoded from IDLE
  assign tmo = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT));
  assign src = tmo ? IDLE : state_q;

  always_comb begin
    state_d = src;
    acap_d  = acap_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    fun_d   = fun_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    alu_d   = 1'b0;
    err_d   = tmo;
    if (vld || tmo || state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (vld) begin
      unique case (src)
        IDLE: begin
          unique case (1'b1)
            (din == OPC_WR):  state_d = WR_ADDR;
            (din == OPC_RD):  state_d = RD_ADDR;
            (din == OPC_ALU): state_d = OP_A;
            (din == OPC_FUN): state_d = ALU_FUN_ST;
            default:          err_d   = 1'b1;
          endcase
        end
        WR_ADDR: begin
          acap_d  = din[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
        WR_DATA: begin
          wr_d    = 1'b1;
          addr_d  = acap_q;
          wdat_d  = din;
          state_d = IDLE;
        end
        RD_ADDR: begin
          rd_d    = 1'b1;
          addr_d  = din[ADDR_WIDTH-1:0];
          state_d = IDLE;
        end
        OP_A: begin
          wr_d    = 1'b1;
          addr_d  = ADDR_WIDTH'(0);
          wdat_d  = din;
          state_d = OP_B;
        end
        OP_B: begin
          wr_d    = 1'b1;
          addr_d  = ADDR_WIDTH'(1);
          wdat_d  = din;
          state_d = ALU_FUN_ST;
        end
        ALU_FUN_ST: begin
          alu_d   = 1'b1;
          fun_d   = din[FUN_WIDTH-1:0];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Gate stays open across the whole ALU frame and its strobe
    gate_d = alu_d ||
             (state_d == OP_A) ||
             (state_d == OP_B) ||
             (state_d == ALU_FUN_ST);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acap_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      fun_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      alu_q   <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acap_q  <= acap_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      fun_q   <= fun_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.WrEn        = wr_q;
  assign bus.RdEn        = rd_q;
  assign bus.Address     = addr_q;
  assign bus.WrData      = wdat_q;
  assign bus.ALU_EN      = alu_q;
  assign bus.ALU_FUN     = fun_q;
  assign bus.CLK_GATE_EN = gate_q;
  assign bus.CMD_Busy    = busy_q;
  assign bus.CMD_ERR     = err_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Self-checking bench for rx_cmd_ctrl against a
// frame-level reference model.
module tb_rx_cmd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int TO = 20;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  rx_cmd_ctrl_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)
  ) bus ();

  rx_cmd_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .FUN_WIDTH(FW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: current opcode (0 = none), bytes seen, idle run
  int       m_op, m_idx, m_idle;
  logic [3:0] m_acap;
  logic     e_wr, e_rd, e_alu, e_gate, e_busy, e_err;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wd;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } stim_t;

  function automatic logic [21:0] obs_vec();
    return {bus.WrEn, bus.RdEn, bus.ALU_EN,
            bus.CLK_GATE_EN, bus.CMD_Busy, bus.CMD_ERR,
            bus.Address, bus.WrData, bus.ALU_FUN};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {e_wr, e_rd, e_alu, e_gate, e_busy, e_err,
            e_addr, e_wd, e_fun};
  endfunction

  function automatic bit is_opc(input logic [7:0] d);
    return d == 8'hAA || d == 8'hBB ||
           d == 8'hCC || d == 8'hDD;
  endfunction

  task automatic model_reset();
    m_op = 0; m_idx = 0; m_idle = 0; m_acap = '0;
    {e_wr, e_rd, e_alu, e_gate, e_busy, e_err} = '0;
    e_addr = '0; e_wd = '0; e_fun = '0;
  endtask

  task automatic model(input logic v, input logic [7:0] d);
    bit tmo;
    tmo = (m_op != 0) && (m_idle == TO);
    if (tmo) m_op = 0;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = tmo;
    if (v) begin
      m_idle = 0;
      if (m_op == 0) begin
        if (is_opc(d)) begin
          m_op = int'(d); m_idx = 0;
        end else e_err = 1;
      end else begin
        case (m_op)
          'hAA: if (m_idx == 0) begin
            m_acap = d[3:0]; m_idx = 1;
          end else begin
            e_wr = 1; e_addr = m_acap; e_wd = d; m_op = 0;
          end
          'hBB: begin
            e_rd = 1; e_addr = d[3:0]; m_op = 0;
          end
          'hCC: if (m_idx < 2) begin
            e_wr = 1; e_addr = m_idx[3:0]; e_wd = d;
            m_idx++;
          end else begin
            e_alu = 1; e_fun = d[3:0]; m_op = 0;
          end
          default: begin
            e_alu = 1; e_fun = d[3:0]; m_op = 0;
          end
        endcase
      end
    end else if (m_op == 0) m_idle = 0;
    else m_idle++;
    e_gate = e_alu || m_op == 'hCC || m_op == 'hDD;
    e_busy = (m_op != 0);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    @(negedge CLK);
    bus.RX_D_VLD  = v;
    bus.RX_P_Data = d;
    @(posedge CLK);
    model(v, d);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus.RX_D_VLD = 1'b0;
    bus.RX_P_Data = 8'h00;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if (obs_vec() !== 22'd0)
      $display("FAIL reset obs=%h exp=%h", obs_vec(), 22'd0);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_write();
    stim_t s[$];
    s = '{'{1, 8'hAA}, '{1, 8'h05}, '{1, 8'h3C},
          '{0, 8'h00}, '{0, 8'h00}};
    foreach (s[i]) begin
      cyc(s[i].v, s[i].d);
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL write c%0d obs=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if ({bus.WrEn, bus.Address, bus.WrData} !== 13'h1_5_3C)
          $display("FAIL write_strobe obs=%h exp=%h",
                   {bus.WrEn, bus.Address, bus.WrData}, 13'h153C);
        else n_pass++;
      end
    end
  endtask

  task automatic test_read();
    stim_t s[$];
    s = '{'{1, 8'hBB}, '{1, 8'h0A}, '{0, 8'h00}};
    foreach (s[i]) begin
      cyc(s[i].v, s[i].d);
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL read c%0d obs=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 1) begin
        n_chk++;
        if ({bus.RdEn, bus.WrEn, bus.ALU_EN, bus.Address}
            !== 7'b100_1010)
          $display("FAIL read_strobe obs=%b exp=%b",
                   {bus.RdEn, bus.WrEn, bus.ALU_EN, bus.Address},
                   7'b1001010);
        else n_pass++;
      end
    end
  endtask

  task automatic test_alu();
    stim_t s[$];
    s = '{'{1, 8'hCC}, '{1, 8'h12}, '{0, 8'h00},
          '{1, 8'h34}, '{1, 8'h02}, '{0, 8'h00}};
    foreach (s[i]) begin
      cyc(s[i].v, s[i].d);
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL alu c%0d obs=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (bus.CLK_GATE_EN !== 1'b0)
      $display("FAIL alu_gate_off obs=%b exp=0", bus.CLK_GATE_EN);
    else n_pass++;
  endtask

  task automatic test_err();
    stim_t s[$];
    s = '{'{1, 8'h55}, '{0, 8'h00}, '{1, 8'hDD},
          '{1, 8'h07}, '{0, 8'h00}};
    foreach (s[i]) begin
      cyc(s[i].v, s[i].d);
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL err c%0d obs=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_timeout(input bit late_byte);
    int errs;
    errs = 0;
    cyc(1, 8'hAA);
    cyc(1, 8'h03);
    for (int i = 0; i < TO + 4; i++) begin
      if (late_byte && i == TO) cyc(1, 8'hBB);
      else if (late_byte && i == TO + 1) cyc(1, 8'h07);
      else cyc(0, 8'h00);
      errs += int'(bus.CMD_ERR);
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL timeout%0d c%0d obs=%h exp=%h",
                 late_byte, i, obs_vec(), exp_vec());
      else n_pass++;
      if (late_byte && i == TO + 1) begin
        n_chk++;
        if ({bus.RdEn, bus.Address} !== 5'h17)
          $display("FAIL timeout_byte obs=%h exp=%h",
                   {bus.RdEn, bus.Address}, 5'h17);
        else n_pass++;
      end
    end
    n_chk++;
    if (errs != 1)
      $display("FAIL timeout_err_count obs=%0d exp=1", errs);
    else n_pass++;
    if (!late_byte) begin
      cyc(1, 8'hBB);
      cyc(1, 8'h03);
      n_chk++;
      if ({bus.RdEn, bus.Address, bus.CMD_Busy} !== 6'b1_0011_0)
        $display("FAIL timeout_read obs=%b exp=%b",
                 {bus.RdEn, bus.Address, bus.CMD_Busy}, 6'b100110);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    cyc(1, 8'hCC);
    @(negedge CLK);
    bus.RX_D_VLD = 1'b0;
    #2 RST = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (obs_vec() !== 22'd0)
      $display("FAIL reset_mid obs=%h exp=%h", obs_vec(), 22'd0);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b1;
    s = '{'{1, 8'hAA}, '{1, 8'h01}, '{1, 8'hFF}};
    foreach (s[i]) begin
      cyc(s[i].v, s[i].d);
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL reset_mid c%0d obs=%h exp=%h",
                 i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if ({bus.WrEn, bus.Address, bus.WrData} !== 13'h1_1_FF)
      $display("FAIL reset_mid_wr obs=%h exp=%h",
               {bus.WrEn, bus.Address, bus.WrData}, 13'h11FF);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [7:0] op;
    int n, r, bad;
    for (int f = 0; f < 120; f++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      begin op = 8'hAA; n = 2; end
      else if (r < 4) begin op = 8'hBB; n = 1; end
      else if (r < 6) begin op = 8'hCC; n = 3; end
      else if (r < 8) begin op = 8'hDD; n = 1; end
      else begin op = 8'($urandom); n = 0; end
      s.push_back('{1, op});
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 15) == 0)
          repeat (TO + $urandom_range(0, 2))
            s.push_back('{0, 8'h00});
        else if ($urandom_range(0, 2) == 0)
          s.push_back('{0, 8'h00});
        s.push_back('{1, 8'($urandom)});
      end
    end
    bad = 0;
    foreach (s[i]) begin
      cyc(s[i].v, s[i].d);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        if (bad < 10)
          $display("FAIL b2b c%0d obs=%h exp=%h",
                   i, obs_vec(), exp_vec());
        bad++;
      end else n_pass++;
      n_chk++;
      if (int'(bus.WrEn) + int'(bus.RdEn) + int'(bus.ALU_EN) > 1)
        $display("FAIL b2b_excl c%0d obs=%b exp=onehot0",
                 i, {bus.WrEn, bus.RdEn, bus.ALU_EN});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_err();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rx_cmd_ctrl.md
RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of received bytes, register data and ALU operands.
REQ-002 Parameter ADDR_WIDTH, default 4: register-file address width.
REQ-003 Parameter FUN_WIDTH, default 4: ALU function code width.
REQ-004 Parameter TIMEOUT, default 1023: inter-byte timeout in CLK cycles.
REQ-005 CLK  input  1  system clock; all state updates on its rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 RX_P_Data  input  DATA_WIDTH  received UART byte.
REQ-008 RX_D_VLD  input  1  byte-valid strobe; each cycle high is one new byte.
REQ-009 WrEn  output  1  register-file write strobe.
REQ-010 RdEn  output  1  register-file read strobe.
REQ-011 Address  output  ADDR_WIDTH  register-file address.
REQ-012 WrData  output  DATA_WIDTH  register-file write data.
REQ-013 ALU_EN  output  1  ALU execute strobe.
REQ-014 ALU_FUN  output  FUN_WIDTH  ALU function code.
REQ-015 CLK_GATE_EN  output  1  ALU clock-gate enable.
REQ-016 CMD_Busy  output  1  high whenever the FSM is not in IDLE.
REQ-017 CMD_ERR  output  1  one-cycle error pulse.

Function
REQ-018 Frame opcodes: 0xAA = write (addr, data); 0xBB = read (addr); 0xCC = ALU with operands (A, B, fun); 0xDD = ALU without operands (fun).
REQ-019 FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN_ST; all transitions occur only on cycles with RX_D_VLD=1, except timeout.
REQ-020 IDLE transitions: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OP_A; 0xDD -> ALU_FUN_ST; any other byte -> stay IDLE and pulse CMD_ERR the next cycle.
REQ-021 Address bytes: capture RX_P_Data[ADDR_WIDTH-1:0]; upper bits are ignored without error.
REQ-022 WR_ADDR: capture address -> WR_DATA; WR_DATA: on data byte, next cycle WrEn=1 for exactly one cycle with Address and WrData = captured values; -> IDLE.
REQ-023 RD_ADDR: on address byte, next cycle RdEn=1 for exactly one cycle with Address = captured value; -> IDLE.
REQ-024 OP_A: on byte, next cycle WrEn pulse with Address=0 and WrData=byte; -> OP_B.
REQ-025 OP_B: on byte, next cycle WrEn pulse with Address=1 and WrData=byte; -> ALU_FUN_ST.
REQ-026 ALU_FUN_ST: on byte, next cycle ALU_EN=1 for one cycle with ALU_FUN = RX_P_Data[FUN_WIDTH-1:0]; -> IDLE.
REQ-027 CLK_GATE_EN is high from the cycle after 0xCC/0xDD is accepted through the ALU_EN cycle inclusive, and low otherwise.
REQ-028 All outputs are registered; strobe latency is exactly 1 cycle after the triggering RX_D_VLD cycle.
REQ-029 Address, WrData and ALU_FUN hold their last values when strobes are low.
REQ-030 WrEn, RdEn and ALU_EN are never high in the same cycle.
REQ-031 Timeout counter: cleared on every RX_D_VLD cycle and while in IDLE; increments otherwise.
REQ-032 When the counter reaches TIMEOUT outside IDLE: return to IDLE, pulse CMD_ERR once, emit no strobe, and drop CLK_GATE_EN.
REQ-033 A byte arriving in the same cycle the timeout fires is processed as an IDLE opcode.
REQ-034 Back-to-back frames with no idle cycles between bytes are accepted without loss.

Reset
REQ-035 While RST=0: FSM=IDLE, timeout counter=0, all outputs=0 (Address, WrData, ALU_FUN included).
REQ-036 Assertion of RST mid-frame discards the partial frame; the first byte after release is decoded as an opcode.

Verification
REQ-037 Bytes AA,05,3C -> one cycle after 0x3C: WrEn=1, Address=5, WrData=0x3C, for one cycle only.
REQ-038 Bytes BB,0A -> RdEn=1 with Address=0xA for one cycle; WrEn and ALU_EN stay 0.
REQ-039 Bytes CC,12,34,02 -> WrEn pulse with Address 0/0x12, then WrEn pulse with Address 1/0x34, then ALU_EN with ALU_FUN=2; CLK_GATE_EN high from CC+1 through the ALU_EN cycle.
REQ-040 Byte 0x55 in IDLE -> CMD_ERR pulse, no other strobe; then DD,07 -> ALU_EN with ALU_FUN=7.
REQ-041 Bytes AA,03 followed by TIMEOUT idle cycles -> CMD_ERR pulse, CMD_Busy=0, no WrEn; then BB,03 -> RdEn with Address=3.
REQ-042 RST pulsed between bytes CC and 12 -> outputs clear; subsequent AA,01,FF -> WrEn with Address=1, WrData=0xFF.
